// File: rtl/fp_adder_arbiter.sv
// fp_adder_arbiter
//   Round-robin arbiter that shares one two-operand stb/ack floating-point
//   adder among N requesters. One addition runs at a time; the arbiter drives
//   the adder's operand and result handshakes itself and returns the sum to
//   the port that won arbitration.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   req_a/req_b   [N*32-1:0]     per-port operands, port i at [32i+31:32i]
//   req_stb/req_ack [N-1:0]      per-port request handshake
//   resp_z        [31:0]         result word, valid while a resp_stb bit is high
//   resp_stb/resp_ack [N-1:0]    per-port result handshake
//   adder_a/adder_b [31:0]       operands to the adder
//   adder_a_stb/_ack, adder_b_stb/_ack   operand handshakes
//   adder_z, adder_z_stb/_ack    result handshake from the adder
//   busy                         high in every state except IDLE
//   grant_id      [IDW-1:0]      index of the current or last granted port
module fp_adder_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*32-1:0] req_a,
  input  logic [N*32-1:0] req_b,
  input  logic [N-1:0]    req_stb,
  output logic [N-1:0]    req_ack,
  output logic [31:0]     resp_z,
  output logic [N-1:0]    resp_stb,
  input  logic [N-1:0]    resp_ack,
  output logic [31:0]     adder_a,
  output logic [31:0]     adder_b,
  output logic            adder_a_stb,
  output logic            adder_b_stb,
  input  logic            adder_a_ack,
  input  logic            adder_b_ack,
  input  logic [31:0]     adder_z,
  input  logic            adder_z_stb,
  output logic            adder_z_ack,
  output logic            busy,
  output logic [IDW-1:0]  grant_id
);

  typedef enum logic [2:0] {IDLE, GRANT, SEND_A, SEND_B, WAIT_Z, RETURN} state_t;

  // Pointer starts at the last port so port 0 wins the first arbitration.
  localparam logic [IDW-1:0] LAST_INIT = IDW'(N - 1);

  state_t         state, state_nxt;
  logic [IDW-1:0] last_grant, last_grant_nxt;
  logic [IDW-1:0] grant_id_nxt;
  logic [IDW-1:0] winner;
  logic [N-1:0]   req_ack_nxt, resp_stb_nxt;
  logic [31:0]    op_b, op_b_nxt;
  logic [31:0]    adder_a_nxt, adder_b_nxt, resp_z_nxt;
  logic           adder_a_stb_nxt, adder_b_stb_nxt, adder_z_ack_nxt;

  // Scan from last+N down to last+1 so the nearest port after last wins.
  function automatic logic [IDW-1:0] rr_pick(input logic [N-1:0]   stb,
                                             input logic [IDW-1:0] last);
    logic [IDW-1:0] pick;
    int             idx;
    pick = last;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(last) + k) % N;
      if (stb[idx]) pick = IDW'(idx);
    end
    return pick;
  endfunction

  assign winner = rr_pick(req_stb, last_grant);

  // NOTE: every signal written below gets its hold value first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt       = state;
    last_grant_nxt  = last_grant;
    grant_id_nxt    = grant_id;
    req_ack_nxt     = req_ack;
    resp_stb_nxt    = resp_stb;
    op_b_nxt        = op_b;
    adder_a_nxt     = adder_a;
    adder_b_nxt     = adder_b;
    resp_z_nxt      = resp_z;
    adder_a_stb_nxt = adder_a_stb;
    adder_b_stb_nxt = adder_b_stb;
    adder_z_ack_nxt = adder_z_ack;

    case (state)
      IDLE: begin
        if (|req_stb) begin
          grant_id_nxt        = winner;
          req_ack_nxt         = '0;
          req_ack_nxt[winner] = 1'b1;
          state_nxt           = GRANT;
        end
      end
      GRANT: begin
        req_ack_nxt = '0;
        if (req_stb[grant_id]) begin
          adder_a_nxt     = req_a[32*int'(grant_id) +: 32];
          op_b_nxt        = req_b[32*int'(grant_id) +: 32];
          adder_a_stb_nxt = 1'b1;
          state_nxt       = SEND_A;
        end else begin
          // Requester withdrew: the pointer stays put so it is not skipped.
          state_nxt = IDLE;
        end
      end
      SEND_A: begin
        if (adder_a_stb && adder_a_ack) begin
          adder_a_stb_nxt = 1'b0;
          adder_b_nxt     = op_b;
          adder_b_stb_nxt = 1'b1;
          state_nxt       = SEND_B;
        end
      end
      SEND_B: begin
        if (adder_b_stb && adder_b_ack) begin
          adder_b_stb_nxt = 1'b0;
          adder_z_ack_nxt = 1'b1;
          state_nxt       = WAIT_Z;
        end
      end
      WAIT_Z: begin
        if (adder_z_stb && adder_z_ack) begin
          resp_z_nxt             = adder_z;
          adder_z_ack_nxt        = 1'b0;
          resp_stb_nxt           = '0;
          resp_stb_nxt[grant_id] = 1'b1;
          state_nxt              = RETURN;
        end
      end
      RETURN: begin
        // Only the granted port's ack counts; others are ignored.
        if (resp_stb[grant_id] && resp_ack[grant_id]) begin
          resp_stb_nxt   = '0;
          last_grant_nxt = grant_id;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= LAST_INIT;
      grant_id    <= '0;
      req_ack     <= '0;
      resp_stb    <= '0;
      // NOTE: the operand holding register is reset along with the rest so
      // outputs never show stale data after reset, even though it is not
      // observable until reloaded.
      op_b        <= '0;
      adder_a     <= '0;
      adder_b     <= '0;
      resp_z      <= '0;
      adder_a_stb <= 1'b0;
      adder_b_stb <= 1'b0;
      adder_z_ack <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_grant  <= last_grant_nxt;
      grant_id    <= grant_id_nxt;
      req_ack     <= req_ack_nxt;
      resp_stb    <= resp_stb_nxt;
      op_b        <= op_b_nxt;
      adder_a     <= adder_a_nxt;
      adder_b     <= adder_b_nxt;
      resp_z      <= resp_z_nxt;
      adder_a_stb <= adder_a_stb_nxt;
      adder_b_stb <= adder_b_stb_nxt;
      adder_z_ack <= adder_z_ack_nxt;
      busy        <= (state_nxt != IDLE);
    end
  end

endmodule

// File: doc/fp_adder_arbiter.md
# fp_adder_arbiter

Round-robin arbiter sharing one 32-bit floating-point adder (the two-operand stb/ack adder in the taylor datapath) among N requesters. Each requester submits an (a, b) operand pair over an stb/ack handshake and receives its sum z over a second stb/ack handshake. The arbiter runs exactly one addition at a time, drives the adder's get_a/get_b/put_z handshakes itself, and routes the result back to the granted port.

## Interface
Parameters:
- N, 4, number of requester ports (2..8)
- IDW, 2, width of grant_id; must satisfy 2^IDW >= N

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_a  in  N*32  operand a, port i in bits [32i+31:32i]
- req_b  in  N*32  operand b, same packing
- req_stb  in  N  per-port request strobe, held until accepted
- req_ack  out  N  per-port request accept; at most one bit high
- resp_z  out  32  result word, valid while any resp_stb bit is high
- resp_stb  out  N  per-port result strobe; at most one bit high
- resp_ack  in  N  per-port result accept
- adder_a / adder_b  out  32  operands to adder
- adder_a_stb / adder_b_stb  out  1  operand strobes
- adder_a_ack / adder_b_ack  in  1  adder operand accepts
- adder_z  in  32  adder result
- adder_z_stb  in  1  adder result strobe
- adder_z_ack  out  1  result accept to adder
- busy  out  1  high in every state except IDLE
- grant_id  out  IDW  index of current or last granted port

## Operation
- Every handshake transfers on a rising edge where stb and ack are both high. All outputs are registered.
- The state machine has six states: IDLE, GRANT, SEND_A, SEND_B, WAIT_Z, RETURN.
- IDLE: if req_stb is nonzero, choose a winner by round-robin, searching from last_grant+1 and wrapping modulo N. Load grant_id and set req_ack[winner]. Go to GRANT.
- GRANT, with req_stb[grant_id] high: latch req_a/req_b for that port and clear req_ack. Set adder_a_stb and drive adder_a. Go to SEND_A.
- GRANT, with req_stb[grant_id] low (requester withdrew): clear req_ack, go to IDLE, leave last_grant unchanged.
- SEND_A: on adder_a_stb && adder_a_ack, clear adder_a_stb, set adder_b_stb, drive adder_b, go to SEND_B.
- SEND_B: on adder_b_stb && adder_b_ack, clear adder_b_stb, set adder_z_ack, go to WAIT_Z.
- WAIT_Z: on adder_z_stb && adder_z_ack, latch adder_z into resp_z, clear adder_z_ack, set resp_stb[grant_id], go to RETURN.
- RETURN: on resp_stb[grant_id] && resp_ack[grant_id], clear resp_stb, set last_grant = grant_id, go to IDLE.
- Requests arriving while busy wait; req_stb must stay high. No request is dropped or reordered relative to the round-robin pointer.
- The arbiter never inspects operand or result bits. resp_z is adder_z bit-exact, including NaN, inf and signed-zero cases.
- resp_ack bits on non-granted ports, or asserted outside RETURN, are ignored.
- Reset values:
  - state IDLE
  - req_ack, resp_stb = 0
  - adder_a_stb, adder_b_stb, adder_z_ack = 0
  - busy = 0, grant_id = 0, resp_z = 0
  - adder_a, adder_b = 0
  - last_grant = N-1, so port 0 wins the first arbitration
- Reset mid-operation: the arbiter returns to IDLE on the next edge and the in-flight operation is lost. The system must reset the adder in the same cycle, since the arbiter does not resynchronise a half-completed adder transaction.

## Timing
- Request acceptance: req_stb seen high in IDLE at edge E0, req_ack high after E0, operands captured at E1, adder_a_stb high after E1.
- There are zero dead cycles between SEND_A, SEND_B and WAIT_Z beyond those the adder inserts while raising its own acks.
- Result path: adder_z captured at edge Ez, resp_stb high after Ez.
- Back-to-back operations: after the resp_ack edge the arbiter spends one cycle in IDLE, then issues the next req_ack.
- The arbiter's own overhead per operation is 4 cycles: IDLE, GRANT, the RETURN minimum, and the post-return IDLE. Add the adder's latency and any requester back-pressure.
- When resp_ack is held low, the arbiter stalls in RETURN indefinitely. The adder stays idle and no other port is granted.

## Test plan
- Single op, port 0: a=0x3F800000, b=0x40000000 -> resp_stb[0] with resp_z=0x40400000; req_ack pulses exactly once; busy returns to 0.
- All 4 ports request simultaneously and re-request immediately after each response -> grant order 0,1,2,3,0,1; each port receives its own sum. Use port 2 with 0x3F000000+0x3E800000 -> 0x3F400000, and port 3 with 0xBFC00000+0x3FC00000 -> 0x00000000.
- Ports 1 and 2 requesting continuously -> grants alternate 1,2,1,2 and neither port waits more than one operation.
- Port 3 raises req_stb, then drops it in the GRANT cycle -> no adder strobe; state returns to IDLE; a following request from port 3 is still granted next.
- resp_ack[1] held low for 5 cycles with port 0 pending -> resp_stb[1] and resp_z stay stable, port 0 gets no req_ack, and port 0 is granted on the IDLE cycle after the resp_ack[1] edge.
- rst asserted during WAIT_Z (adder reset together) -> all outputs at reset values on the next cycle, and a fresh request completes correctly.
